command_round_robin_scheduler: RTL

COMMAND_ROUND_ROBIN_SCHEDULER -- requirements
Module: command_round_robin_scheduler

---
 rtl/command_round_robin_scheduler_pkg.sv | 47 ++++
 rtl/command_round_robin_scheduler_select.sv | 41 ++++
 rtl/command_round_robin_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/command_round_robin_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// AFU_PKG -- shared types for the command round-robin scheduler.
//   SchedState        : scheduler FSM states
//   CommandBufferLine : one command buffer entry (also the issued command)
//   CMD_LINE_IDLE     : value driven on the command output when nothing issues
// ---------------------------------------------------------------------------
package AFU_PKG;

    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        INIT      = 2'd1,
        ACTIVE    = 2'd2,
        NO_CREDIT = 2'd3
    } SchedState;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        FLUSH   = 2'd3
    } CommandType;

    typedef enum logic [1:0] {
        STRICT   = 2'd0,
        RELAXED  = 2'd1,
        PASSTHRU = 2'd2
    } AbtType;

    typedef struct packed {
        logic        valid;
        logic [7:0]  cmd;
        CommandType  command;
        logic [31:0] address;
        logic [7:0]  size;
        AbtType      abt;
    } CommandBufferLine;

    localparam CommandBufferLine CMD_LINE_IDLE = '{
        valid:   1'b0,
        cmd:     '0,
        command: INVALID,
        address: '0,
        size:    '0,
        abt:     STRICT
    };

endpackage

// File: rtl/command_round_robin_scheduler_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select -- combinational round-robin pick.
// Returns a one-hot vector marking the first set request at or after
// 'pointer', searching upward and wrapping modulo NUM_REQUESTS.
//   requests : request vector
//   pointer  : current priority position
//   grant    : one-hot selection (all zero when no request is set)
// ---------------------------------------------------------------------------
module rr_priority_select
    import AFU_PKG::*;
#(
    parameter int NUM_REQUESTS = 4,
    parameter int PTR_W        = 2
) (
    input  logic [NUM_REQUESTS-1:0] requests,
    input  logic [PTR_W-1:0]        pointer,
    output logic [NUM_REQUESTS-1:0] grant
);

    localparam int unsigned N = NUM_REQUESTS;

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = int'(pointer) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && requests[w_idx[PTR_W-1:0]]) begin
                grant[w_idx[PTR_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/command_round_robin_scheduler.sv
// ---------------------------------------------------------------------------
// command_round_robin_scheduler -- credit-gated round-robin command issuer.
// Picks one requester per cycle (round robin), issues its head command one
// cycle later, and tracks outstanding credits.
//
// Configuration macro: CMD_SCHED_BURST_EN
//   undefined : pointer rotates after every grant, MAX_BURST unused
//   defined   : up to MAX_BURST consecutive grants to the same requester
//
// Ports
//   clock               : clock, rising edge
//   rstn                : asynchronous active-low reset
//   enabled_in          : scheduler enable (registered internally)
//   credits_init        : credit count loaded in INIT
//   credit_return       : one credit returned this cycle
//   command_buffer_in   : head entry of each requester's buffer
//   requests            : requester i has a valid head entry
//   command_arbiter_out : registered issued command (idle value when none)
//   ready               : one-hot grant, requester pops in the same cycle
//   credits_out         : current credit count
//   credit_overflow     : sticky, credit returned while counter all-ones
// ---------------------------------------------------------------------------
module command_round_robin_scheduler
    import AFU_PKG::*;
#(
    parameter int NUM_REQUESTS = 4,
    parameter int CREDIT_WIDTH = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic                                clock,
    input  logic                                rstn,
    input  logic                                enabled_in,
    input  logic [CREDIT_WIDTH-1:0]             credits_init,
    input  logic                                credit_return,
    input  CommandBufferLine [NUM_REQUESTS-1:0] command_buffer_in,
    input  logic [NUM_REQUESTS-1:0]             requests,
    output CommandBufferLine                    command_arbiter_out,
    output logic [NUM_REQUESTS-1:0]             ready,
    output logic [CREDIT_WIDTH-1:0]             credits_out,
    output logic                                credit_overflow
);

    localparam int PTR_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

    if (NUM_REQUESTS < 2 || NUM_REQUESTS > 16) begin : g_bad_num_requests
        $error("NUM_REQUESTS must be in 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..15");
    end

    logic                    r_enabled;
    SchedState               r_state;
    SchedState               w_state_next;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_ptr_next;
    logic [CREDIT_WIDTH-1:0] r_credits;
    logic [CREDIT_WIDTH-1:0] w_credits_next;
    logic                    r_overflow;
    logic                    w_overflow_next;
    CommandBufferLine        r_cmd_out;

    logic [NUM_REQUESTS-1:0] w_onehot;
    logic [PTR_W-1:0]        w_grant_idx;
    logic                    w_grant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == NUM_REQUESTS - 1) ? '0 : p + PTR_W'(1);
    endfunction

    rr_priority_select #(
        .NUM_REQUESTS (NUM_REQUESTS),
        .PTR_W        (PTR_W)
    ) u_select (
        .requests (requests),
        .pointer  (r_ptr),
        .grant    (w_onehot)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
            if (w_onehot[i]) begin
                w_grant_idx = PTR_W'(i);
            end
        end
    end

    // r_enabled (not r_state) gates the grant so dropping the enable blocks
    // grants in the very first cycle the registered enable is low.
    assign w_grant = (r_state == ACTIVE) && r_enabled &&
                     (r_credits != '0) && (requests != '0);
    assign ready   = w_grant ? w_onehot : '0;

    always_comb begin
        w_credits_next  = r_credits;
        w_overflow_next = r_overflow;
        if (r_state == INIT) begin
            w_credits_next = credits_init;
        end else if (w_grant && !credit_return) begin
            w_credits_next = r_credits - CREDIT_ONE;
        end else if (!w_grant && credit_return) begin
            if (r_credits == '1) begin
                w_overflow_next = 1'b1;
            end else begin
                w_credits_next = r_credits + CREDIT_ONE;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!r_enabled) begin
            w_state_next = DISABLED;
        end else begin
            case (r_state)
                DISABLED:  w_state_next = INIT;
                INIT:      w_state_next = ACTIVE;
                ACTIVE:    if (w_credits_next == '0) w_state_next = NO_CREDIT;
                NO_CREDIT: if (w_credits_next != '0) w_state_next = ACTIVE;
                default:   w_state_next = DISABLED;
            endcase
        end
    end

`ifdef CMD_SCHED_BURST_EN
    logic [3:0] r_burst_cnt;
    logic [3:0] w_burst_next;
    logic [3:0] w_run;
    logic       w_leave;

    // w_run is the length of the current run including this grant; a grant
    // away from the pointer starts a fresh run. Leaving ACTIVE always
    // rotates so a stale hold cannot survive a credit stall or disable.
    always_comb begin
        w_leave      = (r_state == ACTIVE) && (w_state_next != ACTIVE);
        w_ptr_next   = r_ptr;
        w_burst_next = r_burst_cnt;
        w_run        = 4'd1;
        if (w_grant) begin
            if (w_grant_idx == r_ptr) begin
                w_run = r_burst_cnt + 4'd1;
            end
            if ((w_run < 4'(MAX_BURST)) && !w_leave) begin
                w_ptr_next   = w_grant_idx;
                w_burst_next = w_run;
            end else begin
                w_ptr_next   = ptr_inc(w_grant_idx);
                w_burst_next = '0;
            end
        end else if ((r_burst_cnt != '0) &&
                     (!requests[r_ptr] || (r_state != ACTIVE) || w_leave)) begin
            w_ptr_next   = ptr_inc(r_ptr);
            w_burst_next = '0;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_burst_next;
        end
    end
`else
    always_comb begin
        w_ptr_next = w_grant ? ptr_inc(w_grant_idx) : r_ptr;
    end
`endif

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_enabled  <= 1'b0;
            r_state    <= DISABLED;
            r_ptr      <= '0;
            r_credits  <= '0;
            r_overflow <= 1'b0;
            r_cmd_out  <= CMD_LINE_IDLE;
        end else begin
            r_enabled  <= enabled_in;
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_credits  <= w_credits_next;
            r_overflow <= w_overflow_next;
            r_cmd_out  <= w_grant ? command_buffer_in[w_grant_idx] : CMD_LINE_IDLE;
        end
    end

    assign command_arbiter_out = r_cmd_out;
    assign credits_out         = r_credits;
    assign credit_overflow     = r_overflow;

endmodule
